vram_arbiter: RTL and testbench

Single-port frame-buffer RAM arbiter between the pixel fetch path, which is driven by the display timing generator, and the game-logic writer. Display reads always win a cycle. Writes are buffered in a small FIFO and drained on free cycles, optionally only during blanking. The block sits between the timing/pixel pipeline and the video RAM, and guarantees that display fetch never stalls.

---
 rtl/vram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// Single-port frame-buffer RAM arbiter: display reads always win a cycle, writer traffic is
// queued in a small FIFO and drained on free cycles (optionally only during blanking).
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int BLANK_ONLY = 0
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        video_on,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic [DATA_W-1:0]           disp_data,
  output logic                        disp_valid,
  input  logic                        wr_valid,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ready,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'b00,
    GNT_READ  = 2'b01,
    GNT_WRITE = 2'b10
  } grant_e;

  // Pointers wrap naturally because the depth is a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1'b1);
  endfunction

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_next_s;
  logic              push_s;
  logic              pop_s;
  logic              write_ok_s;
  grant_e            grant_s;
  grant_e            grant_r;
  logic [ADDR_W-1:0] gnt_addr_r;
  logic [DATA_W-1:0] gnt_data_r;
  logic              rd_tag_r;

  assign push_s     = wr_valid && wr_ready;
  assign write_ok_s = (BLANK_ONLY == 0) || !video_on;

  // Queue storage: only the slot under the write pointer changes, and only on a push.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= wr_addr;
      fifo_data_r[wr_ptr_r] <= wr_data;
    end
  end

  // Occupancy after this edge.
  always_comb begin
    count_next_s = fifo_count;
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count + ONE_C;
      2'b01:   count_next_s = fifo_count - ONE_C;
      default: count_next_s = fifo_count;
    endcase
  end

  // Queue pointers, count and registered ready; a full queue only reopens the cycle after a pop.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
      wr_ready   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      fifo_count <= count_next_s;
      wr_ready   <= (count_next_s < DEPTH_C);
    end
  end

  // Fixed-priority arbitration: display read, then queued write, else idle.
  always_comb begin
    grant_s = GNT_IDLE;
    pop_s   = 1'b0;
    if (disp_req) begin
      grant_s = GNT_READ;
      pop_s   = 1'b0;
    end else if ((fifo_count != {CNT_W{1'b0}}) && write_ok_s) begin
      grant_s = GNT_WRITE;
      pop_s   = 1'b1;
    end else begin
      grant_s = GNT_IDLE;
      pop_s   = 1'b0;
    end
  end

  // Grant stage: captures the winner and its address/data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      grant_r    <= GNT_IDLE;
      gnt_addr_r <= {ADDR_W{1'b0}};
      gnt_data_r <= {DATA_W{1'b0}};
    end else begin
      grant_r <= grant_s;
      case (grant_s)
        GNT_READ: begin
          gnt_addr_r <= disp_addr;
        end
        GNT_WRITE: begin
          gnt_addr_r <= fifo_addr_r[rd_ptr_r];
          gnt_data_r <= fifo_data_r[rd_ptr_r];
        end
        default: begin
          gnt_addr_r <= gnt_addr_r;
        end
      endcase
    end
  end

  // Memory command registers; address and data hold across idle cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (grant_r)
        GNT_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= gnt_addr_r;
        end
        GNT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= gnt_addr_r;
          mem_wdata <= gnt_data_r;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read return: the tag tracks the RAM's one-cycle latency so each read yields one valid.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag_r   <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= {DATA_W{1'b0}};
    end else begin
      rd_tag_r   <= mem_en && !mem_we;
      disp_valid <= rd_tag_r;
      if (rd_tag_r) begin
        disp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vram_arbiter: RAM model, read scoreboard and a BLANK_ONLY=1 second instance.
module tb_vram_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          video_on, disp_req, wr_valid;
  logic [AW-1:0] disp_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] disp_data, mem_wdata, mem_rdata;
  logic          disp_valid, wr_ready, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    fifo_count;

  logic          video_on_b, disp_req_b, wr_valid_b;
  logic [AW-1:0] disp_addr_b, wr_addr_b, mem_addr_b;
  logic [DW-1:0] wr_data_b, disp_data_b, mem_wdata_b, mem_rdata_b;
  logic          disp_valid_b, wr_ready_b, mem_en_b, mem_we_b;
  logic [2:0]    fifo_count_b;

  int            n_checks = 0;
  int            n_errors = 0;
  logic          preload;
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] exp_q [$];

  always #5 clock = ~clock;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .BLANK_ONLY(0)) u_dut (
    .clock(clock), .rst_n(rst_n), .video_on(video_on), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_count(fifo_count)
  );

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .BLANK_ONLY(1)) u_dut_b (
    .clock(clock), .rst_n(rst_n), .video_on(video_on_b), .disp_req(disp_req_b),
    .disp_addr(disp_addr_b), .disp_data(disp_data_b), .disp_valid(disp_valid_b),
    .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .fifo_count(fifo_count_b)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[11:0] ^ 12'h96C;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 19'h00010) return 12'hABC;
    else return pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Synchronous-read RAM model (1-cycle latency), preloaded with a known pattern.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= exp_rd(AW'(i));
      mem_rdata <= 12'h000;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  // Read scoreboard: each accepted request expects one in-order return.
  always @(posedge clock) if (rst_n && disp_req) exp_q.push_back(exp_rd(disp_addr));
  always @(negedge rst_n) exp_q.delete();
  always @(negedge clock) begin
    if (disp_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", 32'(disp_valid), 32'd0);
      else check("rd_data", 32'(disp_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       prev_w;
    int         pending, done;
    int         cnt_exp [5];
    cnt_exp = '{3, 2, 1, 0, 0};
    rst_n = 1'b0; preload = 1'b1;
    video_on = 1'b0; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    video_on_b = 1'b0; disp_req_b = 1'b0; disp_addr_b = '0; wr_valid_b = 1'b0;
    wr_addr_b = '0; wr_data_b = '0; mem_rdata_b = 12'h000;
    repeat (3) step();
    preload = 1'b0;

    // Reset state
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_disp_data", 32'(disp_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_b_outs", 32'({disp_valid_b, wr_ready_b, mem_en_b, mem_we_b, fifo_count_b}), 32'd0);
    check("rst_b_buses", 32'({disp_data_b, mem_addr_b, mem_wdata_b}), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_wr_ready", 32'(wr_ready), 32'd1);
    check("rel_wr_ready_b", 32'(wr_ready_b), 32'd1);

    // Display read of RAM[0x10] = 0xABC
    disp_req = 1'b1; disp_addr = 19'h00010;
    step();
    disp_req = 1'b0;
    check("rd_k_en", 32'(mem_en), 32'd0);
    step();
    check("rd_k1_en", 32'(mem_en), 32'd1);
    check("rd_k1_we", 32'(mem_we), 32'd0);
    check("rd_k1_addr", 32'(mem_addr), 32'h10);
    step();
    check("rd_k2_valid", 32'(disp_valid), 32'd0);
    step();
    check("rd_k3_valid", 32'(disp_valid), 32'd1);
    check("rd_k3_data", 32'(disp_data), 32'hABC);
    step();
    check("rd_k4_valid", 32'(disp_valid), 32'd0);

    // Write latency into an empty queue; video_on is ignored when BLANK_ONLY=0
    video_on = 1'b1;
    wr_valid = 1'b1; wr_addr = 19'h00200; wr_data = 12'h5A5;
    step();
    wr_valid = 1'b0;
    check("wl_count_push", 32'(fifo_count), 32'd1);
    step();
    check("wl_count_pop", 32'(fifo_count), 32'd0);
    check("wl_k1_we", 32'(mem_we), 32'd0);
    step();
    check("wl_k2_en", 32'(mem_en), 32'd1);
    check("wl_k2_we", 32'(mem_we), 32'd1);
    check("wl_k2_addr", 32'(mem_addr), 32'h200);
    check("wl_k2_wdata", 32'(mem_wdata), 32'h5A5);
    step();
    check("wl_k3_we", 32'(mem_we), 32'd0);
    check("wl_hold_addr", 32'(mem_addr), 32'h200);
    check("wl_ram", 32'(ram[10'h200]), 32'h5A5);
    video_on = 1'b0;

    // Contention: writes starve while disp_req is held for 10 cycles
    disp_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_valid = (i < 2);
      wr_addr = AW'(32'h100 + i);
      wr_data = (i == 0) ? 12'h111 : 12'h222;
      disp_addr = AW'(32'h20 + i);
      step();
      check("ct_no_we", 32'(mem_we), 32'd0);
    end
    wr_valid = 1'b0;
    check("ct_count", 32'(fifo_count), 32'd2);
    disp_req = 1'b0;
    step();
    check("ct_d_we", 32'(mem_we), 32'd0);
    check("ct_d_count", 32'(fifo_count), 32'd1);
    step();
    check("ct_w1_we", 32'(mem_we), 32'd1);
    check("ct_w1_addr", 32'(mem_addr), 32'h100);
    step();
    check("ct_w2_we", 32'(mem_we), 32'd1);
    check("ct_w2_addr", 32'(mem_addr), 32'h101);
    step();
    check("ct_end_we", 32'(mem_we), 32'd0);
    check("ct_ram0", 32'(ram[10'h100]), 32'h111);
    check("ct_ram1", 32'(ram[10'h101]), 32'h222);

    // Full queue with a fifth write held off
    disp_req = 1'b1; disp_addr = 19'h00030;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h300 + i); wr_data = DW'(32'hC00 + i);
      step();
    end
    check("ff_count4", 32'(fifo_count), 32'd4);
    check("ff_ready0", 32'(wr_ready), 32'd0);
    wr_addr = 19'h00304; wr_data = 12'hC04;
    step();
    step();
    check("ff_held_count", 32'(fifo_count), 32'd4);
    check("ff_held_ready", 32'(wr_ready), 32'd0);
    check("ff_held_we", 32'(mem_we), 32'd0);
    disp_req = 1'b0;
    step();
    check("ff_p_count", 32'(fifo_count), 32'd3);
    check("ff_p_ready", 32'(wr_ready), 32'd1);
    check("ff_p_we", 32'(mem_we), 32'd0);
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) wr_valid = 1'b0;
      check("ff_drain_we", 32'(mem_we), 32'd1);
      check("ff_drain_addr", 32'(mem_addr), 32'h300 + 32'(j));
      check("ff_drain_wdata", 32'(mem_wdata), 32'hC00 + 32'(j));
      check("ff_drain_count", 32'(fifo_count), 32'(cnt_exp[j]));
    end
    step();
    check("ff_end_we", 32'(mem_we), 32'd0);
    check("ff_ram5", 32'(ram[10'h304]), 32'hC04);

    // Interleaved traffic: writes only after disp_req=0 samples
    disp_req = 1'b1; disp_addr = 19'h00040;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h140 + i); wr_data = DW'(32'hD00 + i);
      step();
    end
    wr_valid = 1'b0;
    check("il_count4", 32'(fifo_count), 32'd4);
    prev_w = 1'b0; pending = 4; done = 0;
    for (int i = 0; i < 10; i++) begin
      disp_req = (i % 2 == 0);
      disp_addr = AW'(32'h40 + i);
      step();
      check("il_we", 32'(mem_we), 32'(prev_w));
      if (prev_w) begin
        check("il_addr", 32'(mem_addr), 32'h140 + 32'(done));
        done++;
      end
      prev_w = !disp_req && (pending > 0);
      if (prev_w) pending--;
    end
    disp_req = 1'b0;
    step();
    check("il_last_we", 32'(mem_we), 32'(prev_w));
    check("il_done", 32'(done), 32'd4);
    check("il_count0", 32'(fifo_count), 32'd0);
    repeat (3) step();

    // Reset mid-operation: 3 queued writes, reads in flight
    disp_req = 1'b1; disp_addr = 19'h00060;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(32'h180 + i); wr_data = DW'(32'hE00 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    check("mr_count3", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mr_outs", 32'({disp_valid, wr_ready, mem_en, mem_we}), 32'd0);
    check("mr_count", 32'(fifo_count), 32'd0);
    check("mr_buses", 32'({disp_data, mem_wdata}), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    disp_req = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("mr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("mr_no_valid", 32'(disp_valid), 32'd0);
      check("mr_no_we", 32'(mem_we), 32'd0);
      step();
    end
    check("mr_ram_untouched", 32'(ram[10'h180]), 32'(pat(19'h00180)));

    // BLANK_ONLY=1 instance: writes wait for video_on=0
    video_on_b = 1'b1;
    wr_valid_b = 1'b1; wr_addr_b = 19'h003A0; wr_data_b = 12'h777;
    step();
    wr_valid_b = 1'b0;
    check("bo_count1", 32'(fifo_count_b), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bo_no_we", 32'(mem_we_b), 32'd0);
    end
    check("bo_still_queued", 32'(fifo_count_b), 32'd1);
    video_on_b = 1'b0;
    step();
    check("bo_j_we", 32'(mem_we_b), 32'd0);
    check("bo_j_count", 32'(fifo_count_b), 32'd0);
    step();
    check("bo_j1_we", 32'(mem_we_b), 32'd1);
    check("bo_j1_addr", 32'(mem_addr_b), 32'h3A0);
    check("bo_j1_wdata", 32'(mem_wdata_b), 32'h777);
    step();
    check("bo_end_we", 32'(mem_we_b), 32'd0);

    check("rd_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
